// File: rtl/game_sequencer_if.sv
// ---------------------------------------------------------------------------
// game_sequencer_if
//
// Signal bundle between the play controller (game_sequencer) and the ball
// engine it sequences.
//
//   ball_y        10  ball engine -> sequencer : ball vertical position
//   erase_enable   1  ball engine -> sequencer : brick-hit pulse
//   paddle_hit     1  ball engine -> sequencer : paddle-bounce pulse
//   all_cleared    1  ball engine -> sequencer : every brick destroyed (level)
//   ball_reset     1  sequencer -> ball engine : synchronous reset (serve)
//   ball_tick      1  sequencer -> ball engine : single-cycle update enable
//
// Modports: master = sequencer side, slave = ball engine side.
// ---------------------------------------------------------------------------
interface game_sequencer_if;
    logic [9:0] ball_y;
    logic       erase_enable;
    logic       paddle_hit;
    logic       all_cleared;
    logic       ball_reset;
    logic       ball_tick;

    modport master (
        input  ball_y,
        input  erase_enable,
        input  paddle_hit,
        input  all_cleared,
        output ball_reset,
        output ball_tick
    );

    modport slave (
        output ball_y,
        output erase_enable,
        output paddle_hit,
        output all_cleared,
        input  ball_reset,
        input  ball_tick
    );
endinterface

// File: rtl/game_sequencer.sv
// ---------------------------------------------------------------------------
// game_sequencer
//
// Play controller for the Breakout datapath. Serves the ball (holds the ball
// engine in reset), paces it with a frame-rate update enable, detects a miss
// or a cleared field, keeps lives and score, and arbitrates the brick, paddle
// and miss sounds onto a single tone code.
//
// Ports:
//   clk         in   system clock
//   reset       in   asynchronous, active-low reset
//   launch      in   serve/start button (debounced, synchronous)
//   ball        if   ball engine bundle (master side, see game_sequencer_if)
//   lives       out  remaining lives
//   score       out  current score (saturating)
//   state       out  FSM state code for the HUD
//   sound_code  out  0 none, 1 brick, 2 paddle, 3 miss
//
// Every output comes straight from a flop.
// ---------------------------------------------------------------------------
module game_sequencer #(
    parameter int unsigned TICK_DIV     = 833334,   // clk cycles per ball update, >= 2
    parameter int unsigned SERVE_CYCLES = 4,        // ball_reset hold in SERVE, >= 1
    parameter int unsigned LIVES_INIT   = 3,        // 1..7
    parameter logic [9:0]  MISS_Y       = 10'd473,  // ball_y above this is a miss
    parameter int unsigned POINTS       = 10,       // per brick, must be < 2**SCORE_W
    parameter int unsigned SCORE_W      = 12,
    parameter int unsigned SOUND_LEN    = 5000000   // tone length in cycles, >= 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   launch,
    game_sequencer_if.master       ball,
    output logic [2:0]             lives,
    output logic [SCORE_W-1:0]     score,
    output logic [2:0]             state,
    output logic [1:0]             sound_code
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_MISS  = 3'd3,
        ST_WIN   = 3'd4,
        ST_OVER  = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        SND_NONE   = 2'd0,
        SND_BRICK  = 2'd1,
        SND_PADDLE = 2'd2,
        SND_MISS   = 2'd3
    } sound_t;

    localparam int unsigned TICK_W  = $clog2(TICK_DIV);
    localparam int unsigned SERVE_W = $clog2(SERVE_CYCLES + 1);
    localparam int unsigned SOUND_W = $clog2(SOUND_LEN + 1);

    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

    // Priority rank of a tone code; the numeric codes are not in priority order.
    function automatic logic [1:0] sound_rank(input sound_t code);
        case (code)
            SND_MISS:   sound_rank = 2'd3;
            SND_BRICK:  sound_rank = 2'd2;
            SND_PADDLE: sound_rank = 2'd1;
            default:    sound_rank = 2'd0;
        endcase
    endfunction

    state_t              state_q;
    state_t              state_next;
    logic                launch_q;
    logic                launch_rise;
    logic                game_start;
    logic                miss_enter;
    logic                ball_reset_next;
    logic                ball_tick_next;
    logic [SERVE_W-1:0]  serve_cnt;
    logic [TICK_W-1:0]   tick_cnt;
    logic [SOUND_W-1:0]  sound_cnt;
    sound_t              sound_q;
    sound_t              sound_req;
    logic                serve_done;
    logic                tick_wrap;
    logic [SCORE_W:0]    score_sum;

    assign launch_rise = launch & ~launch_q;
    assign serve_done  = (serve_cnt == SERVE_W'(SERVE_CYCLES - 1));
    assign tick_wrap   = (tick_cnt == TICK_W'(TICK_DIV - 1));
    assign score_sum   = {1'b0, score} + (SCORE_W + 1)'(POINTS);

    assign state      = state_q;
    assign sound_code = sound_q;

    // -----------------------------------------------------------------------
    // FSM next-state and registered-output decode
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the case can leave one unassigned and infer a latch.
        state_next      = state_q;
        game_start      = 1'b0;
        miss_enter      = 1'b0;
        ball_reset_next = 1'b0;
        ball_tick_next  = 1'b0;

        case (state_q)
            ST_IDLE, ST_WIN, ST_OVER: begin
                if (launch_rise) begin
                    state_next = ST_SERVE;
                    game_start = 1'b1;
                end
            end
            ST_SERVE: begin
                if (serve_done) begin
                    state_next = ST_PLAY;
                end
            end
            ST_PLAY: begin
                // A cleared field outranks a miss seen in the same cycle.
                if (ball.all_cleared) begin
                    state_next = ST_WIN;
                end else if (ball.ball_y > MISS_Y) begin
                    state_next = ST_MISS;
                    miss_enter = 1'b1;
                end
            end
            ST_MISS: begin
                state_next = (lives <= 3'd1) ? ST_OVER : ST_SERVE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // Outputs are decoded from the next state so the registered copies
        // line up with the state register.
        ball_reset_next = (state_next == ST_IDLE) || (state_next == ST_SERVE);
        // Suppressed on the edge that leaves PLAY so no tick escapes PLAY.
        ball_tick_next  = (state_q == ST_PLAY) && (state_next == ST_PLAY) && tick_wrap;
    end

    // Highest-priority tone request this cycle; brick and paddle only count in PLAY.
    always_comb begin
        sound_req = SND_NONE;
        if (miss_enter) begin
            sound_req = SND_MISS;
        end else if (state_q == ST_PLAY && ball.erase_enable) begin
            sound_req = SND_BRICK;
        end else if (state_q == ST_PLAY && ball.paddle_hit) begin
            sound_req = SND_PADDLE;
        end
    end

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_next;
        end
    end

    // -----------------------------------------------------------------------
    // Registered outputs, counters, lives and score
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            launch_q        <= 1'b0;
            ball.ball_reset <= 1'b1;
            ball.ball_tick  <= 1'b0;
            serve_cnt       <= '0;
            tick_cnt        <= '0;
            lives           <= 3'(LIVES_INIT);
            score           <= '0;
        end else begin
            launch_q        <= launch;
            ball.ball_reset <= ball_reset_next;
            ball.ball_tick  <= ball_tick_next;

            // Serve counter: cleared on entry, counts while serving.
            if (state_next == ST_SERVE && state_q != ST_SERVE) begin
                serve_cnt <= '0;
            end else if (state_q == ST_SERVE) begin
                serve_cnt <= serve_cnt + SERVE_W'(1);
            end

            // Tick counter: cleared on entry to PLAY, wraps at TICK_DIV-1.
            if (state_next == ST_PLAY && state_q != ST_PLAY) begin
                tick_cnt <= '0;
            end else if (state_q == ST_PLAY) begin
                tick_cnt <= tick_wrap ? '0 : tick_cnt + TICK_W'(1);
            end

            if (game_start) begin
                lives <= 3'(LIVES_INIT);
            end else if (state_q == ST_MISS && lives != 3'd0) begin
                lives <= lives - 3'd1;
            end

            if (game_start) begin
                score <= '0;
            end else if (state_q == ST_PLAY && ball.erase_enable) begin
                score <= score_sum[SCORE_W] ? SCORE_MAX : score_sum[SCORE_W-1:0];
            end
        end
    end

    // -----------------------------------------------------------------------
    // Sound arbiter: a strictly higher-ranked request (re)starts the tone,
    // anything else while busy is dropped; the code clears when the
    // countdown has run SOUND_LEN cycles.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sound_q   <= SND_NONE;
            sound_cnt <= '0;
        end else if (sound_req != SND_NONE && sound_rank(sound_req) > sound_rank(sound_q)) begin
            sound_q   <= sound_req;
            sound_cnt <= SOUND_W'(SOUND_LEN - 1);
        end else if (sound_q != SND_NONE) begin
            if (sound_cnt == '0) begin
                sound_q <= SND_NONE;
            end else begin
                sound_cnt <= sound_cnt - SOUND_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_game_sequencer.sv
// ---------------------------------------------------------------------------
// tb_game_sequencer
//
// Self-checking bench for game_sequencer with small parameters
// (TICK_DIV=4, SERVE_CYCLES=4, SCORE_W=5, SOUND_LEN=6). Direct checks cover
// state, lives, score, ball_reset and ball_tick; tones are scored by a
// monitor that measures each sound_code run against a queue of expected
// {code, length} entries pushed when the stimulus is driven.
// ---------------------------------------------------------------------------
module tb_game_sequencer;

    localparam int TICK_DIV     = 4;
    localparam int SERVE_CYCLES = 4;
    localparam int LIVES_INIT   = 3;
    localparam int POINTS       = 10;
    localparam int SCORE_W      = 5;
    localparam int SOUND_LEN    = 6;

    localparam int S_IDLE  = 0;
    localparam int S_SERVE = 1;
    localparam int S_PLAY  = 2;
    localparam int S_MISS  = 3;
    localparam int S_WIN   = 4;
    localparam int S_OVER  = 5;

    logic               clk = 1'b0;
    logic               reset;
    logic               launch;
    logic [2:0]         lives;
    logic [SCORE_W-1:0] score;
    logic [2:0]         state;
    logic [1:0]         sound_code;

    game_sequencer_if bus();

    game_sequencer #(
        .TICK_DIV     (TICK_DIV),
        .SERVE_CYCLES (SERVE_CYCLES),
        .LIVES_INIT   (LIVES_INIT),
        .MISS_Y       (10'd473),
        .POINTS       (POINTS),
        .SCORE_W      (SCORE_W),
        .SOUND_LEN    (SOUND_LEN)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .launch     (launch),
        .ball       (bus),
        .lives      (lives),
        .score      (score),
        .state      (state),
        .sound_code (sound_code)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Tone scoreboard
    typedef struct {
        int code;
        int len;
    } tone_t;

    tone_t tone_q[$];
    logic  mon_en = 1'b0;
    int    cur_code = 0;
    int    run_len  = 0;

    task automatic push_tone(input int code, input int len);
        tone_t t;
        t.code = code;
        t.len  = len;
        tone_q.push_back(t);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (int'(sound_code) != cur_code) begin
                if (cur_code != 0) begin
                    if (tone_q.size() == 0) begin
                        check("tone_unexpected", cur_code, 0);
                    end else begin
                        tone_t t;
                        t = tone_q.pop_front();
                        check("tone_code", cur_code, t.code);
                        check("tone_len", run_len, t.len);
                    end
                end
                cur_code = int'(sound_code);
                run_len  = 1;
            end else begin
                run_len++;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset            = 1'b0;
        launch           = 1'b0;
        bus.ball_y       = 10'd100;
        bus.erase_enable = 1'b0;
        bus.paddle_hit   = 1'b0;
        bus.all_cleared  = 1'b0;

        // Reset state
        cycles(3);
        check("rst_state", state, S_IDLE);
        check("rst_lives", lives, 3);
        check("rst_score", score, 0);
        check("rst_ball_reset", bus.ball_reset, 1);
        check("rst_ball_tick", bus.ball_tick, 0);
        check("rst_sound", sound_code, 0);
        reset = 1'b1;
        mon_en = 1'b1;
        cyc();
        check("idle_state", state, S_IDLE);

        // Brick/paddle pulses in IDLE are ignored
        bus.erase_enable = 1'b1;
        bus.paddle_hit   = 1'b1;
        cyc();
        bus.erase_enable = 1'b0;
        bus.paddle_hit   = 1'b0;
        check("idle_erase_score", score, 0);
        check("idle_sound", sound_code, 0);

        // Launch: SERVE for exactly SERVE_CYCLES cycles, then PLAY
        launch = 1'b1;
        cyc();
        launch = 1'b0;
        for (int i = 0; i < SERVE_CYCLES; i++) begin
            if (i != 0) cyc();
            check("serve_state", state, S_SERVE);
            check("serve_ball_reset", bus.ball_reset, 1);
        end
        cyc();
        check("play_state", state, S_PLAY);
        check("play_ball_reset", bus.ball_reset, 0);

        // Tick generation: pulse on cycles 4, 8, ... after PLAY entry
        for (int i = 1; i <= 20; i++) begin
            cyc();
            check("ball_tick", bus.ball_tick, (i % TICK_DIV == 0) ? 1 : 0);
        end
        check("tick_state", state, S_PLAY);

        // Score: 10, 20, 30, then saturate at 31; each hit plays a brick tone
        for (int k = 1; k <= 4; k++) begin
            int exp_score;
            exp_score = (POINTS * k > 31) ? 31 : POINTS * k;
            bus.erase_enable = 1'b1;
            push_tone(1, SOUND_LEN);
            cyc();
            bus.erase_enable = 1'b0;
            check("score", score, exp_score);
            cycles(7);
        end

        // Paddle tone preempted by a brick 2 cycles later
        bus.paddle_hit = 1'b1;
        push_tone(2, 2);
        cyc();
        bus.paddle_hit = 1'b0;
        check("paddle_sound", sound_code, 2);
        cyc();
        bus.erase_enable = 1'b1;
        push_tone(1, SOUND_LEN);
        cyc();
        bus.erase_enable = 1'b0;
        check("preempt_sound", sound_code, 1);
        check("score_hold_sat", score, 31);
        // Paddle during the brick tone is dropped
        bus.paddle_hit = 1'b1;
        cyc();
        bus.paddle_hit = 1'b0;
        check("drop_sound", sound_code, 1);
        cycles(8);

        // ball_y on the boundary is not a miss
        bus.ball_y = 10'd473;
        cycles(3);
        check("no_miss_state", state, S_PLAY);
        check("no_miss_lives", lives, 3);

        // Three misses: lives 3->2->1->0, re-serve after the first two
        for (int k = 0; k < 3; k++) begin
            bus.ball_y = 10'd474;
            push_tone(3, SOUND_LEN);
            cyc();
            bus.ball_y = 10'd100;
            check("miss_state", state, S_MISS);
            check("miss_sound", sound_code, 3);
            check("miss_ball_tick", bus.ball_tick, 0);
            cyc();
            check("miss_lives", lives, 2 - k);
            if (k < 2) begin
                check("reserve_state", state, S_SERVE);
                check("reserve_ball_reset", bus.ball_reset, 1);
                cycles(SERVE_CYCLES);
                check("reserve_play", state, S_PLAY);
                cycles(3);
            end else begin
                check("over_state", state, S_OVER);
                check("over_ball_reset", bus.ball_reset, 0);
            end
        end
        cycles(8);
        check("over_hold_state", state, S_OVER);
        check("over_hold_lives", lives, 0);
        check("over_ball_tick", bus.ball_tick, 0);

        // New game from OVER
        launch = 1'b1;
        cyc();
        launch = 1'b0;
        check("restart_state", state, S_SERVE);
        check("restart_score", score, 0);
        check("restart_lives", lives, 3);
        cycles(SERVE_CYCLES);
        check("restart_play", state, S_PLAY);
        bus.erase_enable = 1'b1;
        push_tone(1, SOUND_LEN);
        cyc();
        bus.erase_enable = 1'b0;
        check("restart_score_hit", score, 10);
        cycles(8);

        // WIN beats a simultaneous miss
        bus.all_cleared = 1'b1;
        bus.ball_y      = 10'd480;
        cyc();
        bus.all_cleared = 1'b0;
        bus.ball_y      = 10'd100;
        check("win_state", state, S_WIN);
        check("win_lives", lives, 3);
        check("win_sound", sound_code, 0);
        check("win_ball_tick", bus.ball_tick, 0);
        cyc();
        check("win_ball_reset", bus.ball_reset, 0);
        bus.erase_enable = 1'b1;
        cyc();
        bus.erase_enable = 1'b0;
        check("win_erase_score", score, 10);
        check("win_erase_sound", sound_code, 0);
        launch = 1'b1;
        cyc();
        launch = 1'b0;
        check("win_relaunch_state", state, S_SERVE);
        check("win_relaunch_score", score, 0);
        check("win_relaunch_lives", lives, 3);
        check("win_relaunch_ball_reset", bus.ball_reset, 1);
        cycles(SERVE_CYCLES);
        check("final_play", state, S_PLAY);

        // Asynchronous reset mid-tone clears everything without a clock edge
        bus.paddle_hit = 1'b1;
        push_tone(2, 1);
        cyc();
        bus.paddle_hit = 1'b0;
        check("pre_reset_sound", sound_code, 2);
        cyc();
        reset = 1'b0;
        #2;
        check("async_sound", sound_code, 0);
        check("async_state", state, S_IDLE);
        check("async_ball_reset", bus.ball_reset, 1);
        check("async_lives", lives, 3);
        @(posedge clk);
        #1;
        reset = 1'b1;
        cycles(3);
        check("tone_queue_empty", tone_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/game_sequencer.md
Name: game_sequencer

Overview:
- Top-level play controller for the Breakout datapath.
- Sequences the ball engine: drives its synchronous reset (serve) and a frame-rate update enable. Detects miss and win, and counts lives and score.
- Arbitrates the two ball sound requests, plus a miss tone, onto one tone-code output for the audio block.
- Sits between the button/VGA timing logic and the ball and paddle engines.

Parameters:
- TICK_DIV, 833334: clk cycles per ball update (60 Hz at 50 MHz); ≥2.
- SERVE_CYCLES, 4: cycles ball_reset is held in SERVE; ≥1.
- LIVES_INIT, 3: lives at game start; 1..7.
- MISS_Y, 10'd473: ball_y strictly above this is a miss.
- POINTS, 10: score added per brick hit.
- SCORE_W, 12: score width.
- SOUND_LEN, 5000000: tone duration in cycles; ≥1.

Ports:
- clk in 1: system clock.
- reset in 1: asynchronous, active-low (0 = reset).
- launch in 1: serve/start button, already debounced and synchronous.
- ball_y in 10: ball engine y position.
- erase_enable in 1: brick-hit pulse from ball engine.
- paddle_hit in 1: paddle-bounce pulse from ball engine.
- all_cleared in 1: level high when every brick is destroyed.
- ball_reset out 1: synchronous reset to ball engine.
- ball_tick out 1: single-cycle ball update enable.
- lives out 3: remaining lives.
- score out SCORE_W: current score.
- state out 3: FSM state code, for HUD display.
- sound_code out 2: 0 none, 1 brick, 2 paddle, 3 miss.

Behaviour:
- Reset (async assert, sync release): state=IDLE, ball_reset=1, ball_tick=0, lives=LIVES_INIT, score=0, sound_code=0, tick counter=0, serve counter=0, launch_q=0.
- All outputs are registered.
- Launch edge: launch_rise = launch & ~launch_q; launch_q is registered every cycle.

State encoding and transitions:
- IDLE=0: ball_reset=1. On launch_rise → SERVE; lives=LIVES_INIT, score=0.
- SERVE=1: ball_reset=1 for exactly SERVE_CYCLES cycles, then → PLAY.
  - Serve counter is cleared on entry.
  - Every serve restores the brick field; this is decided behaviour.
- PLAY=2: ball_reset=0; tick counter runs.
  - Priority: all_cleared → WIN; else ball_y > MISS_Y → MISS.
  - When both hold in the same cycle, WIN wins.
- MISS=3: one cycle.
  - lives decrements.
  - If the pre-decrement value was 1 → OVER, else → SERVE.
  - Issues a miss tone.
- WIN=4 and OVER=5:
  - ball_tick=0; ball_reset=0, so the final ball position stays frozen on screen.
  - On launch_rise → SERVE with lives=LIVES_INIT and score=0.
- Codes 6 and 7 are unreachable; if ever decoded, next state is IDLE.

Tick generation:
- Counter is cleared on entry to PLAY.
- In PLAY it increments each cycle. At count TICK_DIV-1: ball_tick=1 for one cycle and the counter wraps to 0.
- ball_tick is never 1 outside PLAY, including the cycle the FSM leaves PLAY.

Score:
- An erase_enable pulse sampled in PLAY adds POINTS.
- Saturates at 2^SCORE_W-1; never wraps.
- Pulses are ignored outside PLAY.

lives:
- Only changes in MISS or on game start.
- Never underflows below 0.

Sound arbitration:
- Priority: miss(3) > brick(1) > paddle(2).
- Idle: the highest-priority pending request loads sound_code and starts a SOUND_LEN countdown.
- Busy: a strictly higher-priority request preempts, reloading code and countdown.
- Busy: an equal- or lower-priority request is dropped.
- At countdown expiry, sound_code returns to 0.
- Brick and paddle requests are accepted only in PLAY. The miss request is generated internally on MISS entry.

Mid-operation reset: the async reset aborts any state, including an active tone, immediately.

Test Plan:
- Reset low 3 cycles, release, then launch pulse:
  - After reset: state=0, lives=3, score=0, ball_reset=1.
  - After launch: SERVE for exactly 4 cycles with ball_reset=1, then state=2 and ball_reset=0.
- TICK_DIV=4 in PLAY for 20 cycles → ball_tick high on cycles 4, 8, 12, 16, 20 after PLAY entry; each pulse is 1 cycle wide.
- Drive ball_y=474 in PLAY three times, re-serving after each miss:
  - After each miss: lives 3→2→1→0.
  - Final state=5 (OVER); sound_code=3 for SOUND_LEN cycles after each miss.
  - ball_y=473 causes no miss.
- SCORE_W=5, POINTS=10, four erase_enable pulses in PLAY → score 10, 20, 30, 31 (saturates). A pulse in IDLE leaves score unchanged.
- paddle_hit then erase_enable 2 cycles later → sound_code 2→1 (preempt). A paddle_hit during the brick tone leaves the code at 1.
- all_cleared=1 and ball_y=480 in the same PLAY cycle → state=4 (WIN), lives unchanged. A later launch pulse → SERVE with score=0 and lives=3.
